// File: rtl/port_debounce.sv
// Debounced switch/key port: two-flop sync, per-bit stability counter,
// rising-edge flags with read-to-clear, and a registered processor read port.
module port_debounce #(
   parameter int unsigned N         = 10,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [N-1:0]  SW,
   input  logic          RdEn,
   input  logic [1:0]    Sel,
   output logic [15:0]   DOUT,
   output logic          Irq
);

   localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [N-1:0]  s1;
   logic [N-1:0]  s2;
   logic [N-1:0]  deb;
   logic [N-1:0]  deb_nxt;
   logic [N-1:0]  edge_flag;
   logic [N-1:0]  edge_nxt;
   logic [N-1:0]  rise;
   logic [CW-1:0] cnt     [N];
   logic [CW-1:0] cnt_nxt [N];
   logic          rd_clear;
   logic [15:0]   dout_nxt;

   // Per-bit stability counter; the level is accepted on the last stable sample
   always_comb begin
      deb_nxt = deb;
      for (int i = 0; i < N; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != deb[i]) begin
            if (cnt[i] == CNT_LAST) begin
               deb_nxt[i] = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   // A rise arriving on a clearing read survives; the read returns pre-edge flags
   always_comb begin
      rise     = deb_nxt & ~deb;
      rd_clear = RdEn && (Sel == 2'd1);
      edge_nxt = (rd_clear ? '0 : edge_flag) | rise;
   end

   always_comb begin
      dout_nxt = DOUT;
      if (RdEn) begin
         unique case (Sel)
            2'd0:    dout_nxt = 16'(deb);
            2'd1:    dout_nxt = 16'(edge_flag);
            2'd2:    dout_nxt = {15'b0, |edge_flag};
            default: dout_nxt = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         s1        <= '0;
         s2        <= '0;
         deb       <= '0;
         edge_flag <= '0;
         DOUT      <= '0;
         Irq       <= 1'b0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         s1        <= SW;
         s2        <= s1;
         deb       <= deb_nxt;
         edge_flag <= edge_nxt;
         DOUT      <= dout_nxt;
         Irq       <= |edge_nxt;
         for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_port_debounce.sv
// Self-checking bench for port_debounce (N=10, DB_CYCLES=4): read results are
// queued as expectations when a read is issued and compared when DOUT updates.
module tb_port_debounce;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  sw;
   logic        rd_en;
   logic [1:0]  sel;
   logic [15:0] dout;
   logic        irq;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [15:0] exp_q [$];

   port_debounce #(.N(10), .DB_CYCLES(4)) dut (
      .Clock (clk),
      .Reset (rst),
      .SW    (sw),
      .RdEn  (rd_en),
      .Sel   (sel),
      .DOUT  (dout),
      .Irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle read: expectation queued with the request, checked after the edge
   task automatic rd(input string tag, input logic [1:0] s, input logic [15:0] e);
      logic [15:0] want;
      rd_en = 1'b1;
      sel   = s;
      exp_q.push_back(e);
      tick();
      rd_en = 1'b0;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 16'hFFFF, 16'h0000);
      end else begin
         want = exp_q.pop_front();
         check(tag, dout, want);
      end
   endtask

   initial begin
      rst   = 1'b1;
      sw    = '0;
      rd_en = 1'b0;
      sel   = 2'd0;
      tick(2);
      check("rst_dout", dout, 16'h0000);
      check("rst_irq", 16'(irq), 16'h0000);
      rst = 1'b0;

      // single bit rise: accepted exactly six edges after the change
      sw = 10'h001;
      tick(5);
      check("rise0_early_irq", 16'(irq), 16'h0000);
      tick();
      check("rise0_irq", 16'(irq), 16'h0001);
      rd("rise0_deb", 2'd0, 16'h0001);
      tick();
      check("dout_hold", dout, 16'h0001);
      rd("rise0_sel2", 2'd2, 16'h0001);
      rd("rise0_edge", 2'd1, 16'h0001);
      check("rise0_irq_clr", 16'(irq), 16'h0000);

      // glitch on bit 3 shorter than the debounce window
      sw = 10'h009;
      tick(3);
      sw = 10'h001;
      tick(8);
      check("glitch_irq", 16'(irq), 16'h0000);
      rd("glitch_deb", 2'd0, 16'h0001);
      rd("glitch_edge", 2'd1, 16'h0000);

      // two bits pending, read-to-clear
      sw = 10'h007;
      tick(6);
      check("rise12_irq", 16'(irq), 16'h0001);
      rd("rise12_edge", 2'd1, 16'h0006);
      check("rise12_irq_clr", 16'(irq), 16'h0000);
      rd("rise12_edge2", 2'd1, 16'h0000);

      // clearing read coincides with the rise of bit 5
      sw = 10'h027;
      tick(5);
      rd("race5_edge", 2'd1, 16'h0000);
      check("race5_irq", 16'(irq), 16'h0001);
      rd("race5_edge2", 2'd1, 16'h0020);
      check("race5_irq_clr", 16'(irq), 16'h0000);

      // falling bit 0 sets no flag
      sw = 10'h026;
      tick(6);
      check("fall0_irq", 16'(irq), 16'h0000);
      rd("fall0_sel2", 2'd2, 16'h0000);
      rd("fall0_sel3", 2'd3, 16'h0000);
      rd("fall0_deb", 2'd0, 16'h0026);

      // all bits rise, then asynchronous reset between edges
      sw = 10'h000;
      tick(6);
      rd("all_low_deb", 2'd0, 16'h0000);
      sw = 10'h3FF;
      tick(6);
      check("all_irq", 16'(irq), 16'h0001);
      rd("all_sel2", 2'd2, 16'h0001);
      rd("all_sel3", 2'd3, 16'h0000);
      rd("all_deb", 2'd0, 16'h03FF);
      #2 rst = 1'b1;
      #1;
      check("async_dout", dout, 16'h0000);
      check("async_irq", 16'(irq), 16'h0000);
      #2 rst = 1'b0;

      // switches already high after reset are accepted as fresh rises
      rd("post_rst_edge", 2'd1, 16'h0000);
      tick(4);
      check("post_rst_early_irq", 16'(irq), 16'h0000);
      tick();
      check("post_rst_irq", 16'(irq), 16'h0001);
      rd("post_rst_deb", 2'd0, 16'h03FF);
      rd("post_rst_edge2", 2'd1, 16'h03FF);

      // reset mid-count discards the partial count
      sw = 10'h000;
      tick(6);
      rd("pre_mid_deb", 2'd0, 16'h0000);
      sw = 10'h001;
      tick(3);
      #2 rst = 1'b1;
      sw = 10'h000;
      #2 rst = 1'b0;
      tick(8);
      check("mid_rst_irq", 16'(irq), 16'h0000);
      rd("mid_rst_deb", 2'd0, 16'h0000);
      rd("mid_rst_edge", 2'd1, 16'h0000);

      if (exp_q.size() != 0) check("queue_drain", 16'(exp_q.size()), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/port_debounce.md
PORT_DEBOUNCE -- requirements
Module: port_debounce

Interface
REQ-001 SHALL have parameter N, default 10: number of switch inputs, 1..16.
REQ-002 SHALL have parameter DB_CYCLES, default 4: consecutive stable samples required to accept a new level, 2..65535.
REQ-003 SHALL have port Clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port SW, input, N: raw asynchronous switch/key levels.
REQ-006 SHALL have port RdEn, input, 1: bus read strobe from the processor-side address decode.
REQ-007 SHALL have port Sel, input, 2: register select (bus address bits [1:0]).
REQ-008 SHALL have port DOUT, output, 16: registered read data, feeding the processor DIN mux.
REQ-009 SHALL have port Irq, output, 1: OR of all pending edge flags.

Function
REQ-010 SHALL pass each SW bit through a two-flop synchronizer (S1, S2) before any other use.
REQ-011 SHALL keep one debounced level DEB[i] and one counter CNT[i] per bit; counter width is ceil(log2(DB_CYCLES)).
REQ-012 Per bit, each cycle: S2==DEB -> CNT<=0; S2!=DEB and CNT<DB_CYCLES-1 -> CNT<=CNT+1; S2!=DEB and CNT==DB_CYCLES-1 -> DEB<=S2, CNT<=0.
REQ-013 Latency: SW change set up before edge k and held stable SHALL appear on DEB at edge k+DB_CYCLES+1; with the default, that is 5 edges.
REQ-014 A glitch that returns S2 to DEB before the count completes SHALL restart the count from 0 and SHALL leave DEB unchanged.
REQ-015 SHALL keep a rising-edge flag register EDGE[N-1:0]; EDGE[i] sets on the same edge at which DEB[i] goes 0->1; falling transitions set nothing.
REQ-016 Read map, sampled at the rising edge when RdEn=1:
- Sel=0 -> DOUT<=zero-extended DEB.
- Sel=1 -> DOUT<=zero-extended EDGE.
- Sel=2 -> DOUT<={15'b0, |EDGE}.
- Sel=3 -> DOUT<=16'h0000.
REQ-017 Read latency SHALL be 1 clock; DOUT SHALL hold its last value while RdEn=0.
REQ-018 A read with Sel=1 SHALL clear EDGE at the same edge (read-to-clear); reads with other Sel values SHALL not modify EDGE.
REQ-019 Simultaneous Sel=1 read and new rise on bit i: DOUT SHALL carry the pre-edge EDGE[i] and EDGE[i] SHALL remain 1 afterwards; no event is lost.
REQ-020 Irq SHALL equal |EDGE, taken from the register with no combinational path from SW.
REQ-021 DOUT bits [15:N] SHALL always be 0.

Reset
REQ-022 Reset=1 SHALL immediately, without waiting for a clock edge, force to 0: S1, S2, DEB, CNT, EDGE, DOUT and Irq.
REQ-023 After Reset deasserts, a switch already high SHALL be accepted as a normal 0->1 change per REQ-013 and SHALL set EDGE.
REQ-024 Reset asserted mid-count SHALL discard the partial count; no flag is set.

Verification (N=10, DB_CYCLES=4)
REQ-025 Reset, then SW=10'h001 before edge k and held -> DEB[0]=1 and EDGE[0]=1 after edge k+5; Irq=1; Sel=0 read -> DOUT=16'h0001.
REQ-026 SW[3] high for 3 cycles, then low -> DEB, EDGE, Irq stay 0; Sel=0 read -> DOUT=16'h0000.
REQ-027 Bits 1 and 2 risen and pending -> Sel=1 read gives DOUT=16'h0006, next cycle EDGE=0, Irq=0; a second Sel=1 read gives DOUT=16'h0000.
REQ-028 Sel=1 read issued on the exact edge DEB[5] rises -> DOUT[5]=0, EDGE[5]=1 after; next Sel=1 read -> DOUT=16'h0020.
REQ-029 SW[0] falling 1->0, held -> DEB[0]=0 after 5 edges, EDGE unchanged; Sel=2 read with nothing pending -> 16'h0000, Sel=3 read -> 16'h0000.
REQ-030 Reset pulsed asynchronously between clock edges while EDGE=10'h3FF and DOUT nonzero -> EDGE, DOUT, Irq read 0 before the next edge.
